// File: rtl/hs4_pkg.sv
// Shared types and constants for the 4-phase bundled-data transmit/receive bridges.
package hs4_pkg;

    typedef enum logic [1:0] {
        HS4_IDLE   = 2'd0,
        HS4_REQ_HI = 2'd1,
        HS4_REQ_LO = 2'd2
    } hs4_state_t;

    localparam int unsigned HS4_SYNC_MIN = 2;

endpackage

// File: rtl/hs4_tx_bridge_if.sv
// Bundle of the upstream valid/ready stream, the 4-phase req/ack/data link and status flags.
interface hs4_tx_bridge_if #(
    parameter int unsigned DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              req;
    logic              ack;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              err;

    // Bridge side.
    modport master (
        input  in_valid, in_data, ack,
        output in_ready, req, out_data, busy, err
    );

    // Environment side: upstream source plus async pipeline.
    modport slave (
        output in_valid, in_data, ack,
        input  in_ready, req, out_data, busy, err
    );
endinterface

// File: rtl/hs4_tx_bridge_sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level; chain resets to 0.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/hs4_tx_bridge.sv
// Clocked-to-async 4-phase bundled-data transmitter with a one-word skid buffer.
// Optional sticky ack timeout enabled by defining HS4_TX_TIMEOUT_EN.
module hs4_tx_bridge
    import hs4_pkg::*;
#(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    hs4_tx_bridge_if.master bus
);
    if (SYNC_STAGES < HS4_SYNC_MIN || TIMEOUT_CYC == 0) begin : g_param_check
        $error("hs4_tx_bridge: SYNC_STAGES must be >= 2 and TIMEOUT_CYC nonzero");
    end

    hs4_state_t        state_q, state_d;
    logic              req_q, req_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              buf_full_q, buf_full_d;
    logic              ack_s;
    logic              accept;
    logic              launch;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.ack),
        .q     (ack_s)
    );

    // Accept needs an empty buffer and launch a full one, so they can never coincide.
    assign accept = bus.in_valid & ~buf_full_q;

    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        out_d      = out_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        launch     = 1'b0;

        if (accept) begin
            buf_d      = bus.in_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            HS4_IDLE: begin
                if (buf_full_q) begin
                    launch = 1'b1;
                end
            end
            HS4_REQ_HI: begin
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = HS4_REQ_LO;
                end
            end
            HS4_REQ_LO: begin
                if (!ack_s) begin
                    if (buf_full_q) begin
                        launch = 1'b1;
                    end else begin
                        state_d = HS4_IDLE;
                    end
                end
            end
            default: begin
                state_d = HS4_IDLE;
            end
        endcase

        // out_data only moves on the edge that raises req, keeping the bundle stable.
        if (launch) begin
            out_d      = buf_q;
            req_d      = 1'b1;
            buf_full_d = 1'b0;
            state_d    = HS4_REQ_HI;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HS4_IDLE;
            req_q      <= 1'b0;
            out_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            out_q      <= out_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
        end
    end

`ifdef HS4_TX_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    always_comb begin
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q != HS4_IDLE && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
        // The handshake keeps waiting; the flag is purely diagnostic.
        if (state_q != HS4_IDLE && cnt_q == CNT_MAX) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready = ~buf_full_q;
    assign bus.req      = req_q;
    assign bus.out_data = out_q;
    assign bus.busy     = (state_q != HS4_IDLE) | buf_full_q;
endmodule

// File: tb/tb_hs4_tx_bridge.sv
// Directed bench for hs4_tx_bridge: expected-word queue plus per-cycle bundle checker.
module tb_hs4_tx_bridge;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned SYNC_STAGES = 2;
    localparam int unsigned TIMEOUT_CYC = 16;

    logic clk;
    logic rst_n;

    hs4_tx_bridge_if #(.DATA_W(DATA_W)) bus_if ();

    hs4_tx_bridge #(
        .DATA_W      (DATA_W),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                rises = 0;
    logic [DATA_W-1:0] last_out = '0;
    logic              prev_req = 1'b0;

    bit bfm_en  = 1'b0;
    int ack_dly = 0;

    task automatic check(input string name, input logic [DATA_W-1:0] act,
                         input logic [DATA_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every launched word must match the next accepted word, and the bundle must hold between rises.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
                last_out = '0;
            end else begin
                if (bus_if.req && !prev_req) begin
                    rises++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_launch", bus_if.out_data, last_out ^ '1);
                    end else begin
                        check("launch_word", bus_if.out_data, exp_q.pop_front());
                    end
                    last_out = bus_if.out_data;
                end else begin
                    check("out_data_stable", bus_if.out_data, last_out);
                end
`ifndef HS4_TX_TIMEOUT_EN
                check("err_tied_low", {31'd0, bus_if.err}, 32'd0);
`endif
                prev_req = bus_if.req;
            end
        end
    end

    // Async-side BFM: each ack phase follows the matching req phase after ack_dly clocks.
    initial begin
        bus_if.ack = 1'b0;
        forever begin
            @(negedge clk);
            if (bfm_en) begin
                if (bus_if.req && !bus_if.ack) begin
                    repeat (ack_dly) @(negedge clk);
                    if (bus_if.req && rst_n) bus_if.ack = 1'b1;
                end else if (!bus_if.req && bus_if.ack) begin
                    repeat (ack_dly) @(negedge clk);
                    bus_if.ack = 1'b0;
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [DATA_W-1:0] w);
        int n = 0;
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = w;
        while (!bus_if.in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready stuck at 0 for word %h", w);
        end else begin
            exp_q.push_back(w);
            @(negedge clk);
            check("in_ready_low_when_full", {31'd0, bus_if.in_ready}, 32'd0);
        end
        bus_if.in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n = 0;
        while (bus_if.busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, bus_if.busy}, 32'd0);
    endtask

    initial begin
        int n;
        int r0;
        rst_n           = 1'b0;
        bus_if.in_valid = 1'b0;
        bus_if.in_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_req", {31'd0, bus_if.req}, 32'd0);
        check("reset_out_data", bus_if.out_data, 32'd0);
        check("reset_busy", {31'd0, bus_if.busy}, 32'd0);
        check("reset_in_ready", {31'd0, bus_if.in_ready}, 32'd1);
        check("reset_err", {31'd0, bus_if.err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: single word with manual ack
        send(32'hA5A5_0001);
        check("t1_req_after_accept", {31'd0, bus_if.req}, 32'd0);
        check("t1_busy_buffered", {31'd0, bus_if.busy}, 32'd1);
        @(negedge clk);
        check("t1_req_rise", {31'd0, bus_if.req}, 32'd1);
        check("t1_out_data", bus_if.out_data, 32'hA5A5_0001);
        bus_if.ack = 1'b1;
        n = 0;
        while (bus_if.req && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("t1_req_fall_cycles", n, SYNC_STAGES + 1);
        bus_if.ack = 1'b0;
        wait_idle("t1_idle", 6);
        check("t1_in_ready", {31'd0, bus_if.in_ready}, 32'd1);

        // 2: back-to-back words with a fast async side
        bfm_en  = 1'b1;
        ack_dly = 0;
        r0      = rises;
        send(32'd1);
        send(32'd2);
        send(32'd3);
        wait_idle("t2_idle", 500);
        check("t2_pulses", rises - r0, 3);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: slow ack; in_data wiggles while a word is buffered
        ack_dly = 40;
        r0      = rises;
        send(32'h0000_0044);
        send(32'h0000_0055);
        bus_if.in_data = 32'hDEAD_BEEF;
        repeat (10) @(negedge clk);
        bus_if.in_data = 32'h1234_0000;
        wait_idle("t3_idle", 2000);
        check("t3_pulses", rises - r0, 2);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: reset while req is high
        bfm_en = 1'b0;
        @(negedge clk);
        send(32'h1234_5678);
        @(negedge clk);
        check("t4_req_high", {31'd0, bus_if.req}, 32'd1);
        #2;
        rst_n      = 1'b0;
        bus_if.ack = 1'b0;
        #1;
        check("t4_rst_req", {31'd0, bus_if.req}, 32'd0);
        check("t4_rst_busy", {31'd0, bus_if.busy}, 32'd0);
        check("t4_rst_out_data", bus_if.out_data, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bfm_en  = 1'b1;
        ack_dly = 0;
        r0      = rises;
        send(32'h0000_0007);
        wait_idle("t4_idle", 500);
        check("t4_pulses", rises - r0, 1);
        check("t4_last_word", last_out, 32'h0000_0007);

        // 5: spurious ack while idle
        bfm_en     = 1'b0;
        @(negedge clk);
        bus_if.ack = 1'b1;
        r0         = rises;
        repeat (10) @(negedge clk);
        check("t5_no_req", {31'd0, bus_if.req}, 32'd0);
        check("t5_not_busy", {31'd0, bus_if.busy}, 32'd0);
        check("t5_no_pulse", rises - r0, 0);
        bus_if.ack = 1'b0;
        repeat (5) @(negedge clk);

`ifdef HS4_TX_TIMEOUT_EN
        // 6: withheld ack trips the sticky timeout without aborting
        send(32'h0000_0066);
        @(negedge clk);
        repeat (10) @(negedge clk);
        check("t6_err_early", {31'd0, bus_if.err}, 32'd0);
        n = 0;
        while (!bus_if.err && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6_err_set", {31'd0, bus_if.err}, 32'd1);
        check("t6_req_held", {31'd0, bus_if.req}, 32'd1);
        bus_if.ack = 1'b1;
        repeat (5) @(negedge clk);
        check("t6_req_dropped", {31'd0, bus_if.req}, 32'd0);
        bus_if.ack = 1'b0;
        wait_idle("t6_idle", 10);
        check("t6_err_sticky", {31'd0, bus_if.err}, 32'd1);
`else
        check("t6_err_off", {31'd0, bus_if.err}, 32'd0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, errors so far %0d", errors);
        $fatal(1);
    end
endmodule
